// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the fetch PC controller.
package fetch_ctrl_pkg;
    typedef enum logic [1:0] {BOOT, RUN, WAIT_MEM, WAIT_REDIR} state_t;
    typedef enum logic [1:0] {PRIO_NONE, PRIO_JUMP, PRIO_BRANCH, PRIO_EXC} prio_t;
    localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/redirect_arbiter.sv
// redirect_arbiter: picks the winning redirect (exc > branch > jump) and its flush vector.
module redirect_arbiter
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic        exc_req,
    input  logic        branch_req,
    input  logic [31:0] branch_target,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    output logic        redirect,
    output prio_t       prio,
    output logic [31:0] target,
    output logic [2:0]  flush
);
    assign redirect = exc_req | branch_req | jump_req;
    assign prio = exc_req ? PRIO_EXC : branch_req ? PRIO_BRANCH : jump_req ? PRIO_JUMP : PRIO_NONE;
    assign target = exc_req ? EXC_VECTOR : branch_req ? branch_target : jump_req ? jump_target : '0;
    // flush = {ex, id, if}: deeper redirects kill more of the pipe
    assign flush = {exc_req, exc_req | branch_req, redirect};
endmodule

// File: rtl/fetch_pc_controller.sv
// fetch_pc_controller: sequences PC writes against stalls, redirects and the imem handshake.
module fetch_pc_controller
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc,
    input  logic             stall,
    input  logic             jump_req,
    input  logic [31:0]      jump_target,
    input  logic             branch_req,
    input  logic [31:0]      branch_target,
    input  logic             exc_req,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    output logic             pc_write,
    output logic [31:0]      pc_write_value,
    output logic             fetch_valid,
    output logic             flush_if,
    output logic             flush_id,
    output logic             flush_ex,
    output logic [CNT_W-1:0] redirect_count
);
    state_t      state, next_state;
    logic        pend_valid, pend_load, pend_clear, take, active;
    prio_t       pend_prio, arb_prio;
    logic [31:0] pend_target, arb_target;
    logic        arb_redirect;
    logic [2:0]  arb_flush;

    redirect_arbiter #(.EXC_VECTOR(EXC_VECTOR)) u_arb (
        .exc_req(exc_req),
        .branch_req(branch_req),
        .branch_target(branch_target),
        .jump_req(jump_req),
        .jump_target(jump_target),
        .redirect(arb_redirect),
        .prio(arb_prio),
        .target(arb_target),
        .flush(arb_flush)
    );

    assign imem_addr = pc;
    assign active = !rst && state != BOOT;
    assign imem_req = active;
    assign {flush_ex, flush_id, flush_if} = active ? arb_flush : 3'b000;
    // a new redirect only displaces the pending one if it is at least as urgent
    assign take = arb_redirect && (!pend_valid || arb_prio >= pend_prio);

    always_comb begin
        next_state = state;
        pc_write = 1'b0;
        pc_write_value = '0;
        fetch_valid = 1'b0;
        pend_load = 1'b0;
        pend_clear = 1'b0;
        if (!rst) begin
            case (state)
                BOOT: next_state = RUN;
                RUN, WAIT_MEM: begin
                    if (imem_ready) begin
                        pc_write = arb_redirect | ~stall;
                        pc_write_value = arb_redirect ? arb_target : stall ? '0 : pc + PC_INC;
                        fetch_valid = ~arb_redirect & ~stall;
                        next_state = RUN;
                    end else begin
                        pend_load = arb_redirect;
                        next_state = arb_redirect ? WAIT_REDIR : WAIT_MEM;
                    end
                end
                WAIT_REDIR: begin
                    if (imem_ready) begin
                        pc_write = 1'b1;
                        pc_write_value = take ? arb_target : pend_target;
                        pend_clear = 1'b1;
                        next_state = RUN;
                    end else begin
                        pend_load = take;
                    end
                end
                default: next_state = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pend_valid <= 1'b0;
            pend_prio <= PRIO_NONE;
            pend_target <= '0;
            redirect_count <= '0;
        end else begin
            state <= next_state;
            if (pend_clear) begin
                pend_valid <= 1'b0;
                pend_prio <= PRIO_NONE;
                pend_target <= '0;
            end else if (pend_load) begin
                pend_valid <= 1'b1;
                pend_prio <= arb_prio;
                pend_target <= arb_target;
            end
            if (active && arb_redirect && !(&redirect_count))
                redirect_count <= redirect_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_pc_controller.sv
// tb_fetch_pc_controller: directed vectors with hand-computed expectations.
module tb_fetch_pc_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall, jump_req, branch_req, exc_req, imem_ready;
    logic [31:0] jump_target, branch_target;
    logic        imem_req, pc_write, fetch_valid, flush_if, flush_id, flush_ex;
    logic [31:0] imem_addr, pc_write_value;
    logic [15:0] redirect_count;
    int          checks = 0;
    int          failures = 0;

    fetch_pc_controller dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .stall(stall),
        .jump_req(jump_req),
        .jump_target(jump_target),
        .branch_req(branch_req),
        .branch_target(branch_target),
        .exc_req(exc_req),
        .imem_ready(imem_ready),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .pc_write(pc_write),
        .pc_write_value(pc_write_value),
        .fetch_valid(fetch_valid),
        .flush_if(flush_if),
        .flush_id(flush_id),
        .flush_ex(flush_ex),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic rdy, input logic st,
                         input logic j, input logic b, input logic e);
        pc = p;
        imem_ready = rdy;
        stall = st;
        jump_req = j;
        branch_req = b;
        exc_req = e;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        jump_target = 32'h300;
        branch_target = 32'h400;
        drive(32'h1234, 1, 0, 1, 0, 0);
        check("rst_imem_addr", imem_addr, 32'h1234);
        check("rst_imem_req", imem_req, 0);
        check("rst_pc_write", pc_write, 0);
        check("rst_flush_if", flush_if, 0);
        check("rst_count", redirect_count, 0);
        tick();
        rst = 1'b0;
        drive(32'h0, 1, 0, 1, 0, 0);
        check("boot_pc_write", pc_write, 0);
        check("boot_imem_req", imem_req, 0);
        check("boot_flush_if", flush_if, 0);
        tick();
        drive(32'h0, 1, 0, 0, 0, 0);
        check("seq0_value", pc_write_value, 32'h4);
        check("seq0_write", pc_write, 1);
        check("seq0_valid", fetch_valid, 1);
        check("seq0_imem_req", imem_req, 1);
        check("boot_ignored_count", redirect_count, 0);
        tick();
        drive(32'h4, 1, 0, 0, 0, 0);
        check("seq1_value", pc_write_value, 32'h8);
        tick();
        drive(32'h8, 1, 0, 0, 0, 0);
        check("seq2_value", pc_write_value, 32'hC);
        check("seq2_valid", fetch_valid, 1);
        tick();
        drive(32'h100, 1, 1, 0, 0, 0);
        check("stall0_write", pc_write, 0);
        check("stall0_valid", fetch_valid, 0);
        tick();
        drive(32'h100, 1, 1, 0, 0, 0);
        check("stall1_write", pc_write, 0);
        tick();
        drive(32'h100, 1, 0, 0, 0, 0);
        check("unstall_value", pc_write_value, 32'h104);
        check("unstall_write", pc_write, 1);
        tick();
        drive(32'h200, 1, 0, 1, 1, 0);
        check("br_value", pc_write_value, 32'h400);
        check("br_write", pc_write, 1);
        check("br_valid", fetch_valid, 0);
        check("br_flush", {flush_ex, flush_id, flush_if}, 3'b011);
        tick();
        drive(32'h40, 0, 0, 0, 0, 0);
        check("br_count", redirect_count, 1);
        check("wm_write", pc_write, 0);
        check("wm_valid", fetch_valid, 0);
        tick();
        drive(32'h40, 1, 0, 0, 0, 0);
        check("wm_imem_req", imem_req, 1);
        check("wm_value", pc_write_value, 32'h44);
        check("wm_valid_ready", fetch_valid, 1);
        tick();
        jump_target = 32'h600;
        drive(32'h500, 0, 0, 1, 0, 0);
        check("wr1_write", pc_write, 0);
        check("wr1_flush", {flush_ex, flush_id, flush_if}, 3'b001);
        tick();
        drive(32'h500, 0, 0, 0, 0, 1);
        check("wr2_write", pc_write, 0);
        check("wr2_flush", {flush_ex, flush_id, flush_if}, 3'b111);
        tick();
        jump_target = 32'h700;
        drive(32'h500, 0, 1, 1, 0, 0);
        check("wr3_write", pc_write, 0);
        check("wr3_low_flush", {flush_ex, flush_id, flush_if}, 3'b001);
        tick();
        drive(32'h500, 1, 1, 0, 0, 0);
        check("wr_ready_write", pc_write, 1);
        check("wr_ready_value", pc_write_value, 32'h180);
        check("wr_ready_valid", fetch_valid, 0);
        tick();
        drive(32'h180, 1, 0, 0, 0, 0);
        check("wr_count", redirect_count, 4);
        check("wr_run_value", pc_write_value, 32'h184);
        check("wr_run_valid", fetch_valid, 1);
        tick();
        drive(32'hFFFF_FFFC, 1, 0, 0, 0, 0);
        check("wrap_value", pc_write_value, 32'h0);
        check("wrap_write", pc_write, 1);
        tick();
        branch_target = 32'h900;
        drive(32'h800, 0, 0, 0, 1, 0);
        tick();
        drive(32'h800, 0, 0, 0, 0, 0);
        check("pend_count", redirect_count, 5);
        rst = 1'b1;
        #1;
        check("midrst_count", redirect_count, 0);
        check("midrst_write", pc_write, 0);
        tick();
        rst = 1'b0;
        drive(32'h800, 1, 0, 0, 0, 0);
        check("reboot_write", pc_write, 0);
        tick();
        drive(32'h800, 1, 0, 0, 0, 0);
        check("nostale_value", pc_write_value, 32'h804);
        check("nostale_valid", fetch_valid, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_pc_controller.md
Name: fetch_pc_controller

Overview:
Sequences the program counter register of the pipelined MIPS core. Every cycle it decides whether the PC is written and with what value:
- sequential PC+4, branch target (EX), jump target (ID), or exception vector
- stalled by the hazard unit
- throttled by the instruction-memory ready handshake

It also produces the pipeline flush strobes. It sits between the hazard/branch units and the PC register (pc_write / pc_write_value drive that register's write-enable and data).

Parameters:
EXC_VECTOR, 32'h0000_0180, PC loaded on exception redirect
CNT_W, 16, width of saturating redirect counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
pc  in  32  current PC register value
stall  in  1  hazard-unit stall (load-use); holds PC
jump_req  in  1  jump decoded in ID
jump_target  in  32  jump destination
branch_req  in  1  taken branch resolved in EX
branch_target  in  32  branch destination
exc_req  in  1  exception raised in any stage
imem_ready  in  1  instruction memory returns data this cycle
imem_req  out  1  fetch request; address = imem_addr
imem_addr  out  32  equals pc
pc_write  out  1  PC register write-enable
pc_write_value  out  32  PC register next value
fetch_valid  out  1  instruction on imem data bus may be captured by IF/ID
flush_if  out  1  clear IF/ID
flush_id  out  1  clear ID/EX
flush_ex  out  1  clear EX/MEM
redirect_count  out  CNT_W  saturating count of redirect cycles

Behaviour:
- Async rst:
  - state=BOOT; pend_valid=0, pend_prio=NONE, pend_target=0; redirect_count=0.
  - All outputs 0 while rst is high; imem_addr still follows pc.
  - Reset mid-access discards any pending redirect.
- Redirect arbitration (combinational), priority exc > branch > jump:
  - Winner target: EXC_VECTOR / branch_target / jump_target.
  - Losing requests in the same cycle are ignored.
  - Redirect overrides stall.
- Flushes, asserted in the same cycle the request is seen, in any state except BOOT:
  - exc: flush_if=flush_id=flush_ex=1.
  - branch: flush_if=flush_id=1.
  - jump: flush_if=1.
- redirect_count +1 per cycle with any redirect (outside BOOT); holds at all-ones.
- States: BOOT, RUN, WAIT_MEM, WAIT_REDIR. imem_req=1 in every state except BOOT.
- BOOT:
  - Outputs are 0 and redirect inputs are ignored.
  - Next state RUN unconditionally, so the first fetch starts 1 cycle after rst deasserts.
- RUN/WAIT_MEM with imem_ready=1:
  - Redirect: pc_write=1, value=winner target, fetch_valid=0.
  - Else stall: pc_write=0, fetch_valid=0.
  - Else: pc_write=1, value=pc+4 (mod 2^32; 0xFFFFFFFC -> 0), fetch_valid=1.
  - Next state RUN.
- RUN/WAIT_MEM with imem_ready=0:
  - pc_write=0, fetch_valid=0; pc must stay stable during the access.
  - Redirect: latch winner target/prio into pend, go to WAIT_REDIR.
  - Else go to WAIT_MEM.
- WAIT_REDIR, new redirect seen:
  - Priority >= pend_prio: overwrite pend.
  - Lower priority: ignored for pend, but its flushes still assert.
- WAIT_REDIR, imem_ready=1:
  - pc_write=1; value=pend_target, or a same-cycle redirect of priority >= pend_prio.
  - fetch_valid=0 (wrong-path data); stall ignored.
  - Clear pend; next state RUN.
- pc_write/pc_write_value/fetch_valid/flush_* are Mealy outputs: combinational from state, pend, and inputs. No added latency; the PC register updates on the same edge.

Decomposition:
- Package fetch_ctrl_pkg:
  - state encoding (BOOT, RUN, WAIT_MEM, WAIT_REDIR)
  - priority codes (NONE=0, JUMP=1, BRANCH=2, EXC=3)
  - PC_INC=32'd4
- Sub-module redirect_arbiter (combinational):
  - inputs: requests and targets
  - outputs: redirect, prio, target, flush vector
  - reused for pend compare.

Test Plan:
- Release rst, imem_ready=1, pc=0x0 then follows pc_write_value -> BOOT cycle with no writes; then values 0x4, 0x8, 0xC each cycle, fetch_valid=1.
- pc=0x100, stall=1 for 2 cycles, imem_ready=1 -> pc_write=0 and fetch_valid=0 for 2 cycles; then 0x104.
- pc=0x200, branch_req=1 (0x400) and jump_req=1 (0x300) in the same cycle -> pc_write_value=0x400, flush_if=flush_id=1, flush_ex=0, fetch_valid=0, redirect_count=1.
- pc=0x500, imem_ready=0 for 3 cycles, jump to 0x600 in cycle 1, exc in cycle 2 -> no PC writes while waiting; on ready, pc_write_value=0x180, fetch_valid=0, state RUN.
- pc=0xFFFFFFFC, imem_ready=1, no stall -> pc_write_value=0x0.
- In WAIT_REDIR with branch pending, assert rst -> pend cleared, redirect_count=0; after release, BOOT then a fetch at the current pc with no stale redirect.
